player_ctrl: RTL and testbench

Player cannon controller for Block Invaders. It sits directly downstream of the per-button debounce stage. It takes the debounced left/right/fire levels, resynchronises them to the system clock and converts each press into a single event. From those events it maintains the cannon's horizontal position and a single-bullet flight state machine for the renderer and collision logic.

---
 rtl/player_ctrl_if.sv | 34 +++
 rtl/player_ctrl.sv | 154 +++++++++++++++
 tb/tb_player_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/player_ctrl_if.sv
// ============================================================================
// Module   : player_ctrl_if
// Purpose  : Button/tick/hit inputs and cannon/bullet outputs of player_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface player_ctrl_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           frame_tick;
    logic           btn_left;
    logic           btn_right;
    logic           btn_fire;
    logic           hit;
    logic [X_W-1:0] player_x;
    logic           bullet_active;
    logic [X_W-1:0] bullet_x;
    logic [Y_W-1:0] bullet_y;
    logic [7:0]     shot_count;

    modport master (
        output frame_tick, btn_left, btn_right, btn_fire, hit,
        input  player_x, bullet_active, bullet_x, bullet_y, shot_count
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, btn_fire, hit,
        output player_x, bullet_active, bullet_x, bullet_y, shot_count
    );
endinterface

`default_nettype wire

// File: rtl/player_ctrl.sv
// ============================================================================
// Module   : player_ctrl
// Purpose  : Cannon position and single-bullet flight control from buttons.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module player_ctrl #(
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 600,
    parameter int X_RESET = 300,
    parameter int STEP    = 8,
    parameter int MUZZLE  = 16,
    parameter int Y_START = 440,
    parameter int Y_TOP   = 0,
    parameter int B_STEP  = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    player_ctrl_if.slave  bus
);

    localparam logic [X_W-1:0] C_X_MIN      = X_W'(X_MIN);
    localparam logic [X_W-1:0] C_X_MAX      = X_W'(X_MAX);
    localparam logic [X_W-1:0] C_X_RESET    = X_W'(X_RESET);
    localparam logic [X_W-1:0] C_STEP       = X_W'(STEP);
    localparam logic [X_W-1:0] C_MUZZLE     = X_W'(MUZZLE);
    // Clamp limits are formed as constants so the compare never wraps.
    localparam logic [X_W-1:0] C_X_LEFT_LIM  = X_W'(X_MIN + STEP);
    localparam logic [X_W-1:0] C_X_RIGHT_LIM = X_W'(X_MAX - STEP);
    localparam logic [Y_W-1:0] C_Y_START    = Y_W'(Y_START);
    localparam logic [Y_W-1:0] C_Y_LIM      = Y_W'(Y_TOP + B_STEP);
    localparam logic [Y_W-1:0] C_B_STEP     = Y_W'(B_STEP);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FLY  = 1'b1;

    // Button vector order: [0] left, [1] right, [2] fire.
    logic [2:0]     w_btn;
    logic [2:0]     r_s1;
    logic [2:0]     r_s2;
    logic [2:0]     r_prev;
    logic [2:0]     w_edge;

    logic [0:0]     r_state;
    logic [0:0]     w_state_nxt;
    logic           r_active;

    logic [X_W-1:0] r_player_x;
    logic [X_W-1:0] w_player_x_nxt;
    logic [X_W-1:0] r_bullet_x;
    logic [X_W-1:0] w_bullet_x_nxt;
    logic [Y_W-1:0] r_bullet_y;
    logic [Y_W-1:0] w_bullet_y_nxt;
    logic [7:0]     r_shot;
    logic [7:0]     w_shot_nxt;

    assign w_btn  = {bus.btn_fire, bus.btn_right, bus.btn_left};
    assign w_edge = r_s2 & ~r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 3'b000;
            r_s2   <= 3'b000;
            r_prev <= 3'b000;
        end else begin
            r_s1   <= w_btn;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    always_comb begin
        w_player_x_nxt = r_player_x;
        if (w_edge[0] && !w_edge[1]) begin
            w_player_x_nxt = (r_player_x < C_X_LEFT_LIM) ? C_X_MIN : r_player_x - C_STEP;
        end else if (w_edge[1] && !w_edge[0]) begin
            w_player_x_nxt = (r_player_x > C_X_RIGHT_LIM) ? C_X_MAX : r_player_x + C_STEP;
        end
    end

    // FSM state register; bullet_active is registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= (w_state_nxt == S_FLY);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_edge[2]) w_state_nxt = S_FLY;
            S_FLY: begin
                if (bus.hit || (bus.frame_tick && (r_bullet_y < C_Y_LIM))) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Launch samples the pre-move player_x; a fire edge while flying is dropped.
    always_comb begin
        w_bullet_x_nxt = r_bullet_x;
        w_bullet_y_nxt = r_bullet_y;
        w_shot_nxt     = r_shot;
        case (r_state)
            S_IDLE: begin
                if (w_edge[2]) begin
                    w_bullet_x_nxt = r_player_x + C_MUZZLE;
                    w_bullet_y_nxt = C_Y_START;
                    w_shot_nxt     = (r_shot == 8'hFF) ? r_shot : r_shot + 8'd1;
                end
            end
            S_FLY: begin
                if (bus.hit) begin
                    w_bullet_y_nxt = C_Y_START;
                end else if (bus.frame_tick) begin
                    w_bullet_y_nxt = (r_bullet_y < C_Y_LIM) ? C_Y_START : r_bullet_y - C_B_STEP;
                end
            end
            default: w_bullet_y_nxt = C_Y_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_player_x <= C_X_RESET;
            r_bullet_x <= '0;
            r_bullet_y <= C_Y_START;
            r_shot     <= 8'd0;
        end else begin
            r_player_x <= w_player_x_nxt;
            r_bullet_x <= w_bullet_x_nxt;
            r_bullet_y <= w_bullet_y_nxt;
            r_shot     <= w_shot_nxt;
        end
    end

    assign bus.player_x      = r_player_x;
    assign bus.bullet_active = r_active;
    assign bus.bullet_x      = r_bullet_x;
    assign bus.bullet_y      = r_bullet_y;
    assign bus.shot_count    = r_shot;

endmodule

`default_nettype wire

// File: tb/tb_player_ctrl.sv
// ============================================================================
// Module   : tb_player_ctrl
// Purpose  : Directed self-checking bench for player_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_player_ctrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    player_ctrl_if #(.X_W(10), .Y_W(10)) bus ();

    player_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        bus.frame_tick = 1'b0;
        bus.btn_left   = 1'b0;
        bus.btn_right  = 1'b0;
        bus.btn_fire   = 1'b0;
        bus.hit        = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    // One-cycle press, then enough idle cycles for the event to land and s2 to drop.
    task automatic press(input logic l, input logic r, input logic f);
        bus.btn_left  = l;
        bus.btn_right = r;
        bus.btn_fire  = f;
        step(1);
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_fire  = 1'b0;
        step(4);
    endtask

    task automatic ftick(input int n);
        repeat (n) begin
            bus.frame_tick = 1'b1;
            step(1);
            bus.frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_hit();
        bus.hit = 1'b1;
        step(1);
        bus.hit = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.btn_left = 1'b1;
        rst = 1'b1;
        step(2);
        checks++; if (bus.player_x !== 10'd300) begin errors++; $display("FAIL rst_px got=%0d exp=300", bus.player_x); end
        checks++; if (bus.bullet_active !== 1'b0) begin errors++; $display("FAIL rst_active got=%0b exp=0", bus.bullet_active); end
        checks++; if (bus.bullet_x !== 10'd0) begin errors++; $display("FAIL rst_bx got=%0d exp=0", bus.bullet_x); end
        checks++; if (bus.bullet_y !== 10'd440) begin errors++; $display("FAIL rst_by got=%0d exp=440", bus.bullet_y); end
        checks++; if (bus.shot_count !== 8'd0) begin errors++; $display("FAIL rst_shots got=%0d exp=0", bus.shot_count); end
        rst = 1'b0;
        step(2);
        checks++; if (bus.player_x !== 10'd300) begin errors++; $display("FAIL rst_early_move got=%0d exp=300", bus.player_x); end
        step(1);
        checks++; if (bus.player_x !== 10'd292) begin errors++; $display("FAIL rst_held_left got=%0d exp=292", bus.player_x); end
        step(20);
        bus.btn_left = 1'b0;
        step(5);
        checks++; if (bus.player_x !== 10'd292) begin errors++; $display("FAIL rst_one_event got=%0d exp=292", bus.player_x); end
    endtask

    task automatic test_left_clamp();
        do_reset();
        repeat (37) press(1'b1, 1'b0, 1'b0);
        checks++; if (bus.player_x !== 10'd4) begin errors++; $display("FAIL left_37 got=%0d exp=4", bus.player_x); end
        press(1'b1, 1'b0, 1'b0);
        checks++; if (bus.player_x !== 10'd0) begin errors++; $display("FAIL left_38 got=%0d exp=0", bus.player_x); end
        press(1'b1, 1'b0, 1'b0);
        checks++; if (bus.player_x !== 10'd0) begin errors++; $display("FAIL left_hold got=%0d exp=0", bus.player_x); end
    endtask

    task automatic test_right_clamp();
        do_reset();
        repeat (36) press(1'b0, 1'b1, 1'b0);
        checks++; if (bus.player_x !== 10'd588) begin errors++; $display("FAIL right_36 got=%0d exp=588", bus.player_x); end
        press(1'b0, 1'b1, 1'b0);
        checks++; if (bus.player_x !== 10'd596) begin errors++; $display("FAIL right_37 got=%0d exp=596", bus.player_x); end
        press(1'b0, 1'b1, 1'b0);
        checks++; if (bus.player_x !== 10'd600) begin errors++; $display("FAIL right_38 got=%0d exp=600", bus.player_x); end
        press(1'b0, 1'b1, 1'b0);
        checks++; if (bus.player_x !== 10'd600) begin errors++; $display("FAIL right_hold got=%0d exp=600", bus.player_x); end
        press(1'b1, 1'b1, 1'b0);
        checks++; if (bus.player_x !== 10'd600) begin errors++; $display("FAIL left_right_same got=%0d exp=600", bus.player_x); end
    endtask

    task automatic test_full_flight();
        do_reset();
        press(1'b0, 1'b0, 1'b1);
        checks++; if (bus.bullet_active !== 1'b1) begin errors++; $display("FAIL launch_active got=%0b exp=1", bus.bullet_active); end
        checks++; if (bus.bullet_x !== 10'd316) begin errors++; $display("FAIL launch_bx got=%0d exp=316", bus.bullet_x); end
        checks++; if (bus.bullet_y !== 10'd440) begin errors++; $display("FAIL launch_by got=%0d exp=440", bus.bullet_y); end
        checks++; if (bus.shot_count !== 8'd1) begin errors++; $display("FAIL launch_shots got=%0d exp=1", bus.shot_count); end
        ftick(1);
        checks++; if (bus.bullet_y !== 10'd436) begin errors++; $display("FAIL flight_1 got=%0d exp=436", bus.bullet_y); end
        ftick(109);
        checks++; if (bus.bullet_y !== 10'd0) begin errors++; $display("FAIL flight_110 got=%0d exp=0", bus.bullet_y); end
        checks++; if (bus.bullet_active !== 1'b1) begin errors++; $display("FAIL flight_110_active got=%0b exp=1", bus.bullet_active); end
        ftick(1);
        checks++; if (bus.bullet_active !== 1'b0) begin errors++; $display("FAIL offscreen_active got=%0b exp=0", bus.bullet_active); end
        checks++; if (bus.bullet_y !== 10'd440) begin errors++; $display("FAIL offscreen_by got=%0d exp=440", bus.bullet_y); end
        checks++; if (bus.bullet_x !== 10'd316) begin errors++; $display("FAIL offscreen_bx got=%0d exp=316", bus.bullet_x); end
    endtask

    task automatic test_hit_refire();
        do_reset();
        press(1'b0, 1'b0, 1'b1);
        ftick(5);
        checks++; if (bus.bullet_y !== 10'd420) begin errors++; $display("FAIL five_ticks got=%0d exp=420", bus.bullet_y); end
        press(1'b0, 1'b0, 1'b1);
        checks++; if (bus.shot_count !== 8'd1) begin errors++; $display("FAIL refire_dropped got=%0d exp=1", bus.shot_count); end
        checks++; if (bus.bullet_y !== 10'd420) begin errors++; $display("FAIL refire_by got=%0d exp=420", bus.bullet_y); end
        bus.hit = 1'b1;
        bus.frame_tick = 1'b1;
        step(1);
        bus.hit = 1'b0;
        bus.frame_tick = 1'b0;
        checks++; if (bus.bullet_active !== 1'b0) begin errors++; $display("FAIL hit_active got=%0b exp=0", bus.bullet_active); end
        checks++; if (bus.bullet_y !== 10'd440) begin errors++; $display("FAIL hit_by got=%0d exp=440", bus.bullet_y); end
        pulse_hit();
        checks++; if (bus.bullet_active !== 1'b0) begin errors++; $display("FAIL idle_hit got=%0b exp=0", bus.bullet_active); end
        press(1'b0, 1'b0, 1'b1);
        checks++; if (bus.shot_count !== 8'd2) begin errors++; $display("FAIL second_shot got=%0d exp=2", bus.shot_count); end
        checks++; if (bus.bullet_active !== 1'b1) begin errors++; $display("FAIL second_active got=%0b exp=1", bus.bullet_active); end
    endtask

    task automatic test_fire_move();
        do_reset();
        press(1'b1, 1'b0, 1'b1);
        checks++; if (bus.player_x !== 10'd292) begin errors++; $display("FAIL move_fire_px got=%0d exp=292", bus.player_x); end
        checks++; if (bus.bullet_x !== 10'd316) begin errors++; $display("FAIL move_fire_bx got=%0d exp=316", bus.bullet_x); end
        pulse_hit();
        // Fire edge reaches the FSM in the same cycle as a frame_tick.
        bus.btn_fire = 1'b1;
        step(1);
        bus.btn_fire = 1'b0;
        step(1);
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
        checks++; if (bus.bullet_y !== 10'd440) begin errors++; $display("FAIL launch_tick_by got=%0d exp=440", bus.bullet_y); end
        checks++; if (bus.bullet_x !== 10'd308) begin errors++; $display("FAIL launch_tick_bx got=%0d exp=308", bus.bullet_x); end
        ftick(1);
        checks++; if (bus.bullet_y !== 10'd436) begin errors++; $display("FAIL first_rise got=%0d exp=436", bus.bullet_y); end
    endtask

    task automatic test_long_hold_saturation();
        do_reset();
        bus.btn_fire = 1'b1;
        step(1000);
        bus.btn_fire = 1'b0;
        checks++; if (bus.shot_count !== 8'd1) begin errors++; $display("FAIL long_hold got=%0d exp=1", bus.shot_count); end
        pulse_hit();
        repeat (253) begin
            press(1'b0, 1'b0, 1'b1);
            pulse_hit();
        end
        checks++; if (bus.shot_count !== 8'd254) begin errors++; $display("FAIL shots_254 got=%0d exp=254", bus.shot_count); end
        repeat (47) begin
            press(1'b0, 1'b0, 1'b1);
            pulse_hit();
        end
        checks++; if (bus.shot_count !== 8'd255) begin errors++; $display("FAIL shots_sat got=%0d exp=255", bus.shot_count); end
    endtask

    task automatic test_rst_midflight();
        do_reset();
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        ftick(3);
        bus.btn_left = 1'b1;
        step(1);
        rst = 1'b1;
        bus.btn_left = 1'b0;
        step(1);
        checks++; if (bus.player_x !== 10'd300) begin errors++; $display("FAIL midrst_px got=%0d exp=300", bus.player_x); end
        checks++; if (bus.bullet_active !== 1'b0) begin errors++; $display("FAIL midrst_active got=%0b exp=0", bus.bullet_active); end
        checks++; if (bus.bullet_x !== 10'd0) begin errors++; $display("FAIL midrst_bx got=%0d exp=0", bus.bullet_x); end
        checks++; if (bus.bullet_y !== 10'd440) begin errors++; $display("FAIL midrst_by got=%0d exp=440", bus.bullet_y); end
        checks++; if (bus.shot_count !== 8'd0) begin errors++; $display("FAIL midrst_shots got=%0d exp=0", bus.shot_count); end
        rst = 1'b0;
        step(6);
        checks++; if (bus.player_x !== 10'd300) begin errors++; $display("FAIL midrst_pending got=%0d exp=300", bus.player_x); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        clear_inputs();
        test_reset();
        test_left_clamp();
        test_right_clamp();
        test_full_flight();
        test_hit_refire();
        test_fire_move();
        test_long_hold_saturation();
        test_rst_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
